// File: rtl/wisc_pkg.sv
// wisc_pkg: shared widths, RED sequencer state/byte-select encodings and operand bundle.
// Latency: n/a (declarations and one pure helper function only).
// Backpressure: n/a.
package wisc_pkg;

  localparam int WORD_W    = 16;
  localparam int RED_ACC_W = 10;

  // Sequencer state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] RED_IDLE = 2'd0;
  localparam logic [1:0] RED_ACC  = 2'd1;
  localparam logic [1:0] RED_DONE = 2'd2;

  // Byte order walked by the step counter.
  localparam logic [1:0] RED_SEL_AH = 2'd0;  // A[15:8]
  localparam logic [1:0] RED_SEL_AL = 2'd1;  // A[7:0]
  localparam logic [1:0] RED_SEL_BH = 2'd2;  // B[15:8]
  localparam logic [1:0] RED_SEL_BL = 2'd3;  // B[7:0]

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } red_ops_t;

  function automatic logic [7:0] red_sel_byte(input red_ops_t ops, input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      RED_SEL_AH: v = ops.a[15:8];
      RED_SEL_AL: v = ops.a[7:0];
      RED_SEL_BH: v = ops.b[15:8];
      default:    v = ops.b[7:0];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/red_seq_unit_if.sv
// red_seq_unit_if: operand and result handshake bundle for the sequential RED unit.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//   master: issues A/B with in_valid, consumes Sum with out_ready.
//   slave : the RED unit; drives in_ready, out_valid and Sum.
interface red_seq_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Sum
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Sum
  );
endinterface

// File: rtl/red.sv
// red: combinational byte reduction, sext16(sum of the four signed bytes of A and B).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//   A, B : 16-bit operands   Sum : 16-bit sign-extended result
module red (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum
);
  logic signed [9:0] w_total;

  always_comb begin
    w_total = 10'(signed'(A[15:8])) + 10'(signed'(A[7:0]))
            + 10'(signed'(B[15:8])) + 10'(signed'(B[7:0]));
    Sum     = 16'(w_total);
  end
endmodule

// File: rtl/red_byte_acc.sv
// red_byte_acc: signed accumulator adding one sign-extended byte per enabled cycle.
// Latency: 1 cycle from i_en to o_acc update.
// Backpressure: none; the owner gates i_en.
//   clk, rst : clock and synchronous active-high reset
//   i_clr    : zero the accumulator (wins over i_en)
//   i_en     : add sext(i_byte) this cycle
//   o_acc    : current accumulator value
module red_byte_acc
  import wisc_pkg::*;
#(
  parameter int ACC_W = RED_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [7:0]       i_byte,
  output logic [ACC_W-1:0] o_acc
);
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_ext;

  assign w_ext = {{(ACC_W-8){i_byte[7]}}, i_byte};
  assign o_acc = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_ext;
    end
  end
endmodule

// File: rtl/red_seq_unit.sv
// red_seq_unit: serial RED, four signed bytes summed through one adder, result sign-extended.
// Latency: accept at edge N, out_valid seen after edge N+5 (4 add cycles + 1 result-register cycle).
// Backpressure: in_ready only in IDLE; Sum held stable in DONE until out_ready.
//   clk, rst : clock, synchronous active-high reset (wins over everything)
//   flush    : abandon any in-flight operation, return to IDLE next edge
//   bus      : slave side of red_seq_unit_if (in_valid/in_ready/A/B, out_valid/out_ready/Sum)
module red_seq_unit
  import wisc_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int ACC_W = RED_ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  red_seq_unit_if.slave bus
);
  logic [1:0]       r_state;
  logic [1:0]       r_step;
  logic             r_last;   // all four bytes added; next ACC cycle registers Sum
  red_ops_t         r_ops;
  logic [WIDTH-1:0] r_sum;

  logic             w_accept;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic [7:0]       w_byte;
  logic [ACC_W-1:0] w_acc;

  assign w_accept  = (r_state == RED_IDLE) && bus.in_valid && !flush;
  assign w_acc_clr = w_accept || flush;
  assign w_acc_en  = (r_state == RED_ACC) && !r_last && !flush;
  assign w_byte    = red_sel_byte(r_ops, r_step);

  red_byte_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_acc_clr),
    .i_en   (w_acc_en),
    .i_byte (w_byte),
    .o_acc  (w_acc)
  );

  assign bus.in_ready  = (r_state == RED_IDLE);
  assign bus.out_valid = (r_state == RED_DONE);
  assign bus.Sum       = r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RED_IDLE;
      r_step  <= '0;
      r_last  <= 1'b0;
      r_ops   <= '0;
      r_sum   <= '0;
    end else if (flush) begin
      // Operands are left as-is; they are reloaded on the next accept.
      r_state <= RED_IDLE;
      r_step  <= '0;
      r_last  <= 1'b0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        RED_IDLE: begin
          if (bus.in_valid) begin
            r_ops.a <= bus.A;
            r_ops.b <= bus.B;
            r_step  <= '0;
            r_last  <= 1'b0;
            r_state <= RED_ACC;
          end
        end
        RED_ACC: begin
          if (!r_last) begin
            r_step <= r_step + 2'd1;
            if (r_step == RED_SEL_BL) begin
              r_last <= 1'b1;
            end
          end else begin
            // Accumulator is final; only now expose it so Sum never shows partials.
            r_sum   <= {{(WIDTH-ACC_W){w_acc[ACC_W-1]}}, w_acc};
            r_last  <= 1'b0;
            r_state <= RED_DONE;
          end
        end
        RED_DONE: begin
          if (bus.out_ready) begin
            r_sum   <= '0;
            r_state <= RED_IDLE;
          end
        end
        default: begin
          r_state <= RED_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_red_seq_unit.sv
module tb_red_seq_unit;
  logic clk;
  logic rst;
  logic flush;

  logic [15:0] ref_a;
  logic [15:0] ref_b;
  logic [15:0] ref_sum;

  int n_cmp;
  int n_err;

  red_seq_unit_if #(.WIDTH(16)) bus ();

  red_seq_unit dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  red u_ref (
    .A   (ref_a),
    .B   (ref_b),
    .Sum (ref_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op from IDLE, scramble operands after accept, wait for the result.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                       input string tag, input bit lat_chk);
    int lat;
    int busy_rdy;
    ref_a = a;
    ref_b = b;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    tick;
    bus.in_valid = 1'b0;
    bus.A        = ~a;
    bus.B        = 16'h5A5A;
    lat      = 1;
    busy_rdy = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) busy_rdy++;
      tick;
      lat++;
    end
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
    if (lat_chk) chk({tag, "_lat"}, 32'(lat), 32'd6);
    chk({tag, "_sum"}, 32'(bus.Sum), 32'(exp));
    chk({tag, "_ref"}, 32'(ref_sum), 32'(exp));
    if (bus.out_ready) begin
      tick;
      chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hi_cnt;
    int n_out;
    int n_ovl;
    int n_dup;
    int n_lost;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    ref_a = '0;
    ref_b = '0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;

    // Hand-computed: byte sums of signed bytes, sign-extended.
    vecs[0] = '{16'h0001, 16'h0001, 16'h0002};  // 0+1+0+1
    vecs[1] = '{16'h1234, 16'h5678, 16'h0114};  // 18+52+86+120 = 276
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF};  // -1-1+0+1
    vecs[3] = '{16'hABCD, 16'hDCBA, 16'hFF0E};  // -85-51-36-70 = -242
    vecs[4] = '{16'h7F7F, 16'h7F7F, 16'h01FC};  // 4*127
    vecs[5] = '{16'h8080, 16'h8080, 16'hFE00};  // 4*-128

    tick;
    tick;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.Sum), 32'd0);
    rst = 1'b0;
    tick;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_sum", 32'(bus.Sum), 32'd0);

    // Directed vectors back to back with out_ready held high.
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);

    // Backpressure: 0x0F+0x0F+0x00+(-0x10) = 14.
    bus.out_ready = 1'b0;
    do_op(16'h0F0F, 16'h00F0, 16'h000E, "bp", 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("bp_hold%0d_vld", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_sum", k), 32'(bus.Sum), 32'h000E);
      chk($sformatf("bp_hold%0d_rdy", k), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick;
    chk("bp_release_vld", 32'(bus.out_valid), 32'd0);
    chk("bp_release_rdy", 32'(bus.in_ready), 32'd1);

    // Flush in the 2nd ACC cycle.
    bus.in_valid = 1'b1;
    bus.A = 16'h1234;
    bus.B = 16'h5678;
    tick;
    bus.in_valid = 1'b0;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_acc_rdy", 32'(bus.in_ready), 32'd1);
    chk("flush_acc_vld", 32'(bus.out_valid), 32'd0);
    chk("flush_acc_sum", 32'(bus.Sum), 32'd0);
    hi_cnt = 0;
    repeat (8) begin
      tick;
      if (bus.out_valid) hi_cnt++;
    end
    chk("flush_acc_never_vld", 32'(hi_cnt), 32'd0);

    // Flush together with in_valid in IDLE: nothing accepted.
    bus.in_valid = 1'b1;
    flush = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_rdy", 32'(bus.in_ready), 32'd1);
    hi_cnt = 0;
    repeat (8) begin
      tick;
      if (bus.out_valid || !bus.in_ready) hi_cnt++;
    end
    chk("flush_idle_no_accept", 32'(hi_cnt), 32'd0);

    // Flush in DONE drops the result.
    bus.out_ready = 1'b0;
    do_op(16'h0102, 16'h0304, 16'h000A, "fdone", 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_done_vld", 32'(bus.out_valid), 32'd0);
    chk("flush_done_sum", 32'(bus.Sum), 32'd0);
    chk("flush_done_rdy", 32'(bus.in_ready), 32'd1);

    // Reset in the 3rd ACC cycle, then a fresh op with nominal latency.
    bus.in_valid = 1'b1;
    bus.A = 16'h7F7F;
    bus.B = 16'h7F7F;
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_acc_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_acc_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_acc_sum", 32'(bus.Sum), 32'd0);
    do_op(16'h0001, 16'h0001, 16'h0002, "post_rst", 1'b1);

    // Random soak.
    n_out  = 0;
    n_ovl  = 0;
    n_dup  = 0;
    n_lost = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] got;
      int cyc;
      bit done;
      repeat ($urandom_range(0, 3)) tick;
      a = 16'($urandom);
      b = 16'($urandom);
      ref_a = a;
      ref_b = b;
      cyc = 0;
      while (!bus.in_ready && cyc < 20) begin
        tick;
        cyc++;
      end
      if (!bus.in_ready) chk("soak_rdy_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.A = a;
      bus.B = b;
      tick;
      cyc  = 0;
      done = 1'b0;
      got  = '0;
      while (!done && cyc < 60) begin
        if (bus.in_ready && bus.out_valid) n_ovl++;
        if (bus.in_ready && !bus.out_valid) n_lost++;
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.A         = 16'($urandom);
        bus.B         = 16'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && bus.out_ready) begin
          got  = bus.Sum;
          done = 1'b1;
          n_out++;
        end
        tick;
        cyc++;
        if (n_lost != 0) break;
      end
      bus.in_valid = 1'b0;
      if (done && bus.out_valid) n_dup++;
      chk($sformatf("soak%0d_sum", i), 32'(got), 32'(ref_sum));
      if (n_lost != 0) break;
    end
    chk("soak_outputs", 32'(n_out), 32'd1000);
    chk("soak_overlap", 32'(n_ovl), 32'd0);
    chk("soak_dup", 32'(n_dup), 32'd0);
    chk("soak_lost", 32'(n_lost), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
